// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter_pkg: arbiter state encoding and width helpers                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_ABORT   = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_priority_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter_priority_encoder: one-hot/multi-hot to index priority encoder |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_arbiter_priority_encoder
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 1,
    localparam int OUT_W            = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [OUT_W-1:0] output_encoded
);

    // Scan toward the high-priority end so the last hit is the winner.
    always_comb begin
        output_valid   = |input_unencoded;
        output_encoded = '0;
        if (LSB_HIGH_PRIORITY != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) output_encoded = OUT_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) output_encoded = OUT_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter: Wishbone B4 classic arbiter, N masters onto one slave port   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int IDX_W         = idx_width(NUM_MASTERS)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    output logic                              s_we_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              grant_valid_o,
    output logic [IDX_W-1:0]                  grant_idx_o
);

    localparam int              CNT_W      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_MASTERS - 1);
    localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [IDX_W-1:0]       grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0]       last_idx, last_idx_nxt;
    logic [CNT_W-1:0]       wd_cnt, wd_cnt_nxt;
    logic                   abort_first, abort_first_nxt;

    logic [NUM_MASTERS-1:0] req_masked;
    logic                   masked_valid, all_valid;
    logic [IDX_W-1:0]       masked_idx, all_idx, winner_idx;
    int unsigned            gi;
    logic                   cyc_g, stb_g, we_g, stalled;

    // Round-robin mask: only masters after the previous winner stay eligible.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_mask
        assign req_masked[i] = m_cyc_i[i] && (IDX_W'(i) > last_idx);
    end

    wb_arbiter_priority_encoder #(
        .WIDTH            (NUM_MASTERS),
        .LSB_HIGH_PRIORITY(1)
    ) u_enc_masked (
        .input_unencoded(req_masked),
        .output_valid   (masked_valid),
        .output_encoded (masked_idx)
    );

    wb_arbiter_priority_encoder #(
        .WIDTH            (NUM_MASTERS),
        .LSB_HIGH_PRIORITY(1)
    ) u_enc_all (
        .input_unencoded(m_cyc_i),
        .output_valid   (all_valid),
        .output_encoded (all_idx)
    );

    assign winner_idx = (ROUND_ROBIN != 0 && masked_valid) ? masked_idx : all_idx;

    assign gi      = 32'(grant_idx);
    assign cyc_g   = m_cyc_i[grant_idx];
    assign stb_g   = m_stb_i[grant_idx];
    assign we_g    = m_we_i[grant_idx];
    assign stalled = stb_g && !s_ack_i && !s_err_i;

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        grant_idx_nxt   = grant_idx;
        last_idx_nxt    = last_idx;
        wd_cnt_nxt      = '0;
        abort_first_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (all_valid) begin
                    state_nxt     = ST_GRANTED;
                    grant_idx_nxt = winner_idx;
                    last_idx_nxt  = winner_idx;
                    grant_nxt     = NUM_MASTERS'(1) << winner_idx;
                end
            end
            ST_GRANTED: begin
                if (!cyc_g) begin
                    state_nxt     = ST_IDLE;
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                end else if (TIMEOUT_CYCLES > 0 && stalled) begin
                    // Reaching the last stalled count trips the abort on this edge.
                    if (wd_cnt == WD_LAST) begin
                        state_nxt       = ST_ABORT;
                        abort_first_nxt = 1'b1;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 1'b1;
                    end
                end
            end
            ST_ABORT: begin
                if (!cyc_g) begin
                    state_nxt     = ST_IDLE;
                    grant_nxt     = '0;
                    grant_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                grant_nxt     = '0;
                grant_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            last_idx    <= LAST_RESET;
            wd_cnt      <= '0;
            abort_first <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_idx   <= grant_idx_nxt;
            last_idx    <= last_idx_nxt;
            wd_cnt      <= wd_cnt_nxt;
            abort_first <= abort_first_nxt;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        case (state)
            ST_GRANTED: begin
                s_adr_o              = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o              = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o              = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
                s_we_o               = we_g;
                s_cyc_o              = cyc_g;
                s_stb_o              = stb_g;
                m_ack_o[grant_idx]   = s_ack_i & stb_g;
                m_err_o[grant_idx]   = s_err_i & stb_g;
            end
            ST_ABORT: begin
                m_err_o[grant_idx] = abort_first;
            end
            default: ;
        endcase
    end

    assign m_dat_o       = s_dat_i;
    assign grant_o       = grant;
    assign grant_valid_o = (state != ST_IDLE);
    assign grant_idx_o   = grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter: directed and randomized checks of wb_arbiter (N=3)        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int IW = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [DW-1:0]   s_dat_in;
    logic            s_ack, s_err;

    logic [DW-1:0] m_dat_o;
    logic [N-1:0]  m_ack_o, m_err_o, grant_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o, grant_valid_o;
    logic [IW-1:0] grant_idx_o;

    logic [DW-1:0] f_m_dat_o;
    logic [N-1:0]  f_m_ack_o, f_m_err_o, f_grant_o;
    logic [AW-1:0] f_s_adr_o;
    logic [DW-1:0] f_s_dat_o;
    logic [SW-1:0] f_s_sel_o;
    logic          f_s_we_o, f_s_cyc_o, f_s_stb_o, f_grant_valid_o;
    logic [IW-1:0] f_grant_idx_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant_o), .grant_valid_o(grant_valid_o), .grant_idx_o(grant_idx_o)
    );

    wb_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW),
        .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)
    ) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
        .m_dat_o(f_m_dat_o), .m_ack_o(f_m_ack_o), .m_err_o(f_m_err_o),
        .s_adr_o(f_s_adr_o), .s_dat_o(f_s_dat_o), .s_sel_o(f_s_sel_o),
        .s_we_o(f_s_we_o), .s_cyc_o(f_s_cyc_o), .s_stb_o(f_s_stb_o),
        .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(f_grant_o), .grant_valid_o(f_grant_valid_o), .grant_idx_o(f_grant_idx_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0;
        m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat_in = '0; s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int rr_winner(input logic [N-1:0] req, input int last);
        for (int off = 1; off <= N; off++) begin
            int k;
            k = (last + off) % N;
            if (req[k]) return k;
        end
        return 0;
    endfunction

    task automatic test_reset();
        clear_inputs();
        #2;
        checks++;
        if (grant_o !== 3'b000 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_grant actual=%b/%b/%0d required=000/0/0", grant_o, grant_valid_o, grant_idx_o);
        end
        do_reset();
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || s_adr_o !== '0 || s_dat_o !== '0 || s_sel_o !== '0) begin
            failures++;
            $display("FAIL reset_slave actual=%b adr=%h required=000 adr=0", {s_cyc_o, s_stb_o, s_we_o}, s_adr_o);
        end
        checks++;
        if (m_ack_o !== 3'b000 || m_err_o !== 3'b000 || f_grant_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp actual=%b/%b/%b required=000/000/0", m_ack_o, m_err_o, f_grant_valid_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_adr[0*AW +: AW] = 32'h1000_0000;
        m_adr[1*AW +: AW] = 32'hA5A5_0104;
        m_adr[2*AW +: AW] = 32'h2000_0000;
        m_cyc = 3'b010; m_stb = 3'b010;
        s_dat_in = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (grant_valid_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL single_latency actual=%b/%b required=0/0", grant_valid_o, s_cyc_o);
        end
        step();
        checks++;
        if (grant_o !== 3'b010 || grant_idx_o !== 2'd1 || s_cyc_o !== 1'b1 || s_adr_o !== 32'hA5A5_0104) begin
            failures++;
            $display("FAIL single_grant actual=%b/%0d/%b/%h required=010/1/1/a5a50104", grant_o, grant_idx_o, s_cyc_o, s_adr_o);
        end
        step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 3'b010 || m_err_o !== 3'b000 || m_dat_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_ack actual=%b/%b/%h required=010/000/deadbeef", m_ack_o, m_err_o, m_dat_o);
        end
        step();
        s_ack = 1'b0; m_cyc = 3'b000; m_stb = 3'b000;
        #1;
        checks++;
        if (m_ack_o !== 3'b000) begin
            failures++;
            $display("FAIL single_ack_once actual=%b required=000", m_ack_o);
        end
        step();
        checks++;
        if (grant_valid_o !== 1'b0 || grant_o !== 3'b000) begin
            failures++;
            $display("FAIL single_release actual=%b/%b required=0/000", grant_valid_o, grant_o);
        end
    endtask

    task automatic test_rr_fairness();
        int order[$];
        int gap;
        logic prev_valid;
        logic [N-1:0] last_ack;
        int exp_order[5] = '{0, 1, 2, 0, 1};
        do_reset();
        gap = 0; prev_valid = 1'b0; last_ack = '0;
        s_ack = 1'b1;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            m_cyc = ~last_ack; m_stb = ~last_ack;
            #1;
            if (grant_valid_o && !prev_valid) begin
                order.push_back(int'(grant_idx_o));
                if (order.size() > 1) begin
                    checks++;
                    if (gap != 1) begin
                        failures++;
                        $display("FAIL rr_gap actual=%0d required=1", gap);
                    end
                end
                gap = 0;
            end
            if (!grant_valid_o) gap++;
            prev_valid = grant_valid_o;
            last_ack = m_ack_o;
            step();
        end
        s_ack = 1'b0; m_cyc = '0; m_stb = '0;
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rr_grant_count actual=%0d required=5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d] actual=%0d required=%0d", i, order[i], exp_order[i]);
                end
            end
        end
        step(); step();
    endtask

    task automatic test_fixed();
        do_reset();
        m_cyc = 3'b110; m_stb = 3'b110;
        for (int r = 0; r < 2; r++) begin
            step();
            checks++;
            if (f_grant_valid_o !== 1'b1 || f_grant_idx_o !== 2'd1) begin
                failures++;
                $display("FAIL fixed_grant round%0d actual=%b/%0d required=1/1", r, f_grant_valid_o, f_grant_idx_o);
            end
            s_ack = 1'b1;
            #1;
            checks++;
            if (f_m_ack_o !== 3'b010) begin
                failures++;
                $display("FAIL fixed_ack actual=%b required=010", f_m_ack_o);
            end
            step();
            s_ack = 1'b0; m_cyc = 3'b100; m_stb = 3'b100;
            step();
            m_cyc = 3'b110; m_stb = 3'b110;
        end
        step();
        m_cyc = 3'b111; m_stb = 3'b111;
        step();
        checks++;
        if (f_grant_idx_o !== 2'd1 || f_grant_o !== 3'b010) begin
            failures++;
            $display("FAIL fixed_no_preempt actual=%0d/%b required=1/010", f_grant_idx_o, f_grant_o);
        end
        s_ack = 1'b1;
        step();
        s_ack = 1'b0; m_cyc = 3'b101; m_stb = 3'b101;
        step();
        m_cyc = 3'b111; m_stb = 3'b111;
        step();
        checks++;
        if (f_grant_valid_o !== 1'b1 || f_grant_idx_o !== 2'd0) begin
            failures++;
            $display("FAIL fixed_next_winner actual=%b/%0d required=1/0", f_grant_valid_o, f_grant_idx_o);
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        for (int i = 1; i <= TO; i++) begin
            step();
            checks++;
            if (s_cyc_o !== 1'b1 || m_err_o !== 3'b000) begin
                failures++;
                $display("FAIL timeout_stall%0d actual=%b/%b required=1/000", i, s_cyc_o, m_err_o);
            end
        end
        step();
        checks++;
        if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m_err_o !== 3'b001 || grant_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort actual=%b%b/%b/%b required=00/001/1", s_cyc_o, s_stb_o, m_err_o, grant_valid_o);
        end
        step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_err_o !== 3'b000 || m_ack_o !== 3'b000 || grant_valid_o !== 1'b1 || s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_pulse actual=%b/%b/%b/%b required=000/000/1/0", m_err_o, m_ack_o, grant_valid_o, s_cyc_o);
        end
        step();
        s_ack = 1'b0; m_cyc = 3'b000; m_stb = 3'b000;
        step();
        checks++;
        if (grant_valid_o !== 1'b0 || grant_o !== 3'b000) begin
            failures++;
            $display("FAIL timeout_release actual=%b/%b required=0/000", grant_valid_o, grant_o);
        end
    endtask

    task automatic test_ack_expiry();
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        step(); step(); step(); step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 3'b001 || m_err_o !== 3'b000) begin
            failures++;
            $display("FAIL expiry_ack actual=%b/%b required=001/000", m_ack_o, m_err_o);
        end
        for (int i = 1; i <= TO; i++) begin
            step();
            s_ack = 1'b0;
            #1;
            checks++;
            if (s_cyc_o !== 1'b1 || m_err_o !== 3'b000) begin
                failures++;
                $display("FAIL expiry_no_abort%0d actual=%b/%b required=1/000", i, s_cyc_o, m_err_o);
            end
        end
        step();
        checks++;
        if (m_err_o !== 3'b001 || s_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL expiry_restart actual=%b/%b required=001/0", m_err_o, s_cyc_o);
        end
        m_cyc = '0; m_stb = '0;
        step(); step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_cyc = 3'b100; m_stb = 3'b100;
        step();
        checks++;
        if (grant_idx_o !== 2'd2 || s_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre actual=%0d/%b required=2/1", grant_idx_o, s_cyc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (grant_o !== 3'b000 || grant_valid_o !== 1'b0 || s_cyc_o !== 1'b0 || m_ack_o !== 3'b000) begin
            failures++;
            $display("FAIL midreset_clear actual=%b/%b/%b/%b required=000/0/0/000", grant_o, grant_valid_o, s_cyc_o, m_ack_o);
        end
        m_cyc = 3'b110; m_stb = 3'b110;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (grant_idx_o !== 2'd1 || grant_o !== 3'b010) begin
            failures++;
            $display("FAIL midreset_winner actual=%0d/%b required=1/010", grant_idx_o, grant_o);
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_random();
        bit busy, abort, abort_first;
        int g, last, stall;
        logic [N-1:0] term_prev, exp_ack, exp_err, exp_grant;
        logic exp_cyc, exp_stb;
        logic [AW+DW+SW:0] exp_req;
        do_reset();
        busy = 0; abort = 0; abort_first = 0; g = 0; last = N - 1; stall = 0;
        term_prev = '0;
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (m_cyc[k]) begin
                    if (term_prev[k]) begin
                        m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
                    end else begin
                        m_stb[k] = ($urandom % 4) != 0;
                    end
                end else if (($urandom % 3) == 0) begin
                    m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
                    m_we[k]  = 1'($urandom);
                    m_adr[k*AW +: AW] = $urandom;
                    m_dat[k*DW +: DW] = $urandom;
                    m_sel[k*SW +: SW] = 4'($urandom);
                end
            end
            s_ack = ($urandom % 3) == 0;
            s_err = ($urandom % 16) == 0;
            s_dat_in = $urandom;

            exp_grant = '0; exp_ack = '0; exp_err = '0;
            exp_cyc = 1'b0; exp_stb = 1'b0; exp_req = '0;
            if (busy) begin
                exp_grant[g] = 1'b1;
                if (!abort) begin
                    exp_cyc = m_cyc[g];
                    exp_stb = m_stb[g];
                    exp_req = {m_adr[g*AW +: AW], m_dat[g*DW +: DW], m_sel[g*SW +: SW], m_we[g]};
                    exp_ack[g] = s_ack && m_stb[g];
                    exp_err[g] = s_err && m_stb[g];
                end else begin
                    exp_err[g] = abort_first;
                end
            end
            #1;
            checks++;
            if (grant_valid_o !== busy || grant_o !== exp_grant || grant_idx_o !== IW'(busy ? g : 0)) begin
                failures++;
                $display("FAIL rand_grant cyc%0d actual=%b/%b/%0d required=%b/%b/%0d", c, grant_valid_o, grant_o, grant_idx_o, busy, exp_grant, busy ? g : 0);
            end
            checks++;
            if ({s_cyc_o, s_stb_o} !== {exp_cyc, exp_stb} ||
                (!abort && {s_adr_o, s_dat_o, s_sel_o, s_we_o} !== exp_req)) begin
                failures++;
                $display("FAIL rand_slave cyc%0d actual=%b%b/%h required=%b%b/%h", c, s_cyc_o, s_stb_o, {s_adr_o, s_dat_o, s_sel_o, s_we_o}, exp_cyc, exp_stb, exp_req);
            end
            checks++;
            if (m_ack_o !== exp_ack || m_err_o !== exp_err || m_dat_o !== s_dat_in) begin
                failures++;
                $display("FAIL rand_resp cyc%0d actual=%b/%b/%h required=%b/%b/%h", c, m_ack_o, m_err_o, m_dat_o, exp_ack, exp_err, s_dat_in);
            end
            term_prev = exp_ack | exp_err;

            if (!busy) begin
                if (m_cyc != '0) begin
                    g = rr_winner(m_cyc, last);
                    last = g; busy = 1; abort = 0; stall = 0;
                end
            end else if (!abort) begin
                if (!m_cyc[g]) begin
                    busy = 0;
                end else if (m_stb[g] && !s_ack && !s_err) begin
                    stall++;
                    if (stall == TO) begin
                        abort = 1; abort_first = 1; stall = 0;
                    end
                end else begin
                    stall = 0;
                end
            end else begin
                abort_first = 0;
                if (!m_cyc[g]) begin
                    busy = 0; abort = 0;
                end
            end
            step();
        end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_rr_fairness();
        test_fixed();
        test_timeout();
        test_ack_expiry();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
